// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key front end: symbol encodings, FSM states
// and a helper that sizes the press/gap duration counter.
package morse_pkg;

   localparam logic [1:0] SYM_NONE = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      GAP
   } state_e;

   function automatic int cnt_width(input int max_value);
      return (max_value < 1) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser plus counting debouncer for a slow mechanical key; the
// output level only follows the input after DEBOUNCE_CYCLES disagreeing samples.
module morse_debounce #(
   parameter int DEBOUNCE_CYCLES = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic [DW-1:0] cnt_q;

   // Any sample agreeing with the accepted level restarts the disagreement run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q >= LAST) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/morse_symbol_capture.sv
// Morse key front end: times debounced presses and gaps, packs dots/dashes into
// a letter frame and hands frames and word markers to a one-deep output register.
module morse_symbol_capture
   import morse_pkg::*;
#(
   parameter int UNIT_TIME        = 2000,
   parameter int MAX_SYMBOLS      = 6,
   parameter int DEBOUNCE_CYCLES  = 15,
   parameter int DASH_UNITS       = 3,
   parameter int LONG_PRESS_UNITS = 10,
   parameter int LETTER_GAP_UNITS = 3,
   parameter int WORD_GAP_UNITS   = 7
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             button_i,
   output logic [2*MAX_SYMBOLS-1:0]         code_o,
   output logic [$clog2(MAX_SYMBOLS+1)-1:0] sym_count_o,
   output logic                             word_end_o,
   output logic                             error_o,
   output logic                             out_valid_o,
   input  logic                             out_ready_i,
   output logic                             overrun_o,
   output logic                             busy_o
);

   localparam int CODE_W   = 2 * MAX_SYMBOLS;
   localparam int CNT_W    = $clog2(MAX_SYMBOLS + 1);
   localparam int DASH_T   = DASH_UNITS * UNIT_TIME;
   localparam int LONG_T   = LONG_PRESS_UNITS * UNIT_TIME;
   localparam int LETTER_T = LETTER_GAP_UNITS * UNIT_TIME;
   localparam int WORD_T   = WORD_GAP_UNITS * UNIT_TIME;
   localparam int SAT_T    = (LONG_T > WORD_T) ? LONG_T : WORD_T;
   localparam int TW       = cnt_width(SAT_T);

   localparam logic [TW-1:0]    DASH_L   = TW'(DASH_T);
   localparam logic [TW-1:0]    LONG_L   = TW'(LONG_T);
   localparam logic [TW-1:0]    LETTER_L = TW'(LETTER_T);
   localparam logic [TW-1:0]    WORD_L   = TW'(WORD_T);
   localparam logic [TW-1:0]    SAT_L    = TW'(SAT_T);
   localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_SYMBOLS);

   logic              key;
   state_e            state_q;
   logic [TW-1:0]     time_q;
   logic [TW-1:0]     time_inc_d;
   logic [CODE_W-1:0] code_q;
   logic [CNT_W-1:0]  count_q;
   logic              err_q;
   logic              word_armed_q;
   logic [CODE_W-1:0] out_code_q;
   logic [CNT_W-1:0]  out_count_q;
   logic              out_err_q;
   logic              out_word_q;
   logic              out_valid_q;
   logic              overrun_q;
   logic              busy_q;
   logic [1:0]        sym_d;
   logic              letter_emit_d;
   logic              word_emit_d;
   logic              emit_d;
   logic              can_load_d;

   morse_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (button_i),
      .level_o(key)
   );

   // Thresholds compare the registered duration, so a letter frame lands one
   // cycle after the gap counter reaches the letter threshold.
   always_comb begin
      time_inc_d    = (time_q == SAT_L) ? time_q : time_q + 1'b1;
      sym_d         = (time_q < DASH_L) ? SYM_DOT : ((time_q < LONG_L) ? SYM_DASH : SYM_NONE);
      letter_emit_d = (state_q == GAP) && (time_q >= LETTER_L);
      word_emit_d   = (state_q == IDLE) && word_armed_q && (time_q >= WORD_L);
      emit_d        = letter_emit_d || word_emit_d;
      can_load_d    = !out_valid_q || out_ready_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         time_q       <= '0;
         code_q       <= '0;
         count_q      <= '0;
         err_q        <= 1'b0;
         word_armed_q <= 1'b0;
         out_code_q   <= '0;
         out_count_q  <= '0;
         out_err_q    <= 1'b0;
         out_word_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         overrun_q <= emit_d && !can_load_d;
         if (emit_d && can_load_d) begin
            out_valid_q <= 1'b1;
            out_code_q  <= letter_emit_d ? code_q : '0;
            out_count_q <= letter_emit_d ? count_q : '0;
            out_err_q   <= letter_emit_d && err_q;
            out_word_q  <= word_emit_d;
         end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (key) begin
                  state_q      <= PRESS;
                  busy_q       <= 1'b1;
                  time_q       <= TW'(1);
                  word_armed_q <= 1'b0;
               end else if (word_armed_q) begin
                  time_q <= time_inc_d;
                  if (word_emit_d) begin
                     word_armed_q <= 1'b0;
                  end
               end
            end
            PRESS: begin
               if (key) begin
                  time_q <= time_inc_d;
               end else begin
                  if (sym_d == SYM_NONE || count_q >= MAX_L) begin
                     err_q <= 1'b1;
                  end else begin
                     code_q  <= (code_q << 2) | CODE_W'(sym_d);
                     count_q <= count_q + 1'b1;
                  end
                  state_q <= GAP;
                  time_q  <= TW'(1);
               end
            end
            GAP: begin
               // A press arriving on the closing cycle starts the next letter at once.
               if (letter_emit_d) begin
                  code_q       <= '0;
                  count_q      <= '0;
                  err_q        <= 1'b0;
                  word_armed_q <= !key;
                  state_q      <= key ? PRESS : IDLE;
                  busy_q       <= key;
                  time_q       <= key ? TW'(1) : time_inc_d;
               end else if (key) begin
                  state_q <= PRESS;
                  time_q  <= TW'(1);
               end else begin
                  time_q <= time_inc_d;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign code_o      = out_code_q;
   assign sym_count_o = out_count_q;
   assign word_end_o  = out_word_q;
   assign error_o     = out_err_q;
   assign out_valid_o = out_valid_q;
   assign overrun_o   = overrun_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Bench for morse_symbol_capture: directed and random key sequences compared with
// a run-length reference model of the key timing rules.
module tb_morse_symbol_capture;

   localparam int UT       = 4;
   localparam int DEB      = 2;
   localparam int MAXS     = 4;
   localparam int DASH_T   = 3 * UT;
   localparam int LONG_T   = 10 * UT;
   localparam int LETTER_T = 3 * UT;
   localparam int WORD_T   = 7 * UT;

   typedef struct packed {
      logic [7:0] code;
      logic [2:0] cnt;
      logic       err;
      logic       word;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       button_i = 1'b0;
   logic       out_ready_i = 1'b1;
   logic [7:0] code_o;
   logic [2:0] sym_count_o;
   logic       word_end_o;
   logic       error_o;
   logic       out_valid_o;
   logic       overrun_o;
   logic       busy_o;

   frame_t obsQ[$];
   frame_t expQ[$];
   bit     btnHist[$];
   int     riseCyc[$];
   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   int     overrunCycles = 0;
   int     unstableCycles = 0;
   int     fallRef = 0;
   logic   prevHold = 1'b0;
   logic   prevValid = 1'b0;
   frame_t prevFrame;
   frame_t curFrame;

   morse_symbol_capture #(
      .UNIT_TIME       (UT),
      .MAX_SYMBOLS     (MAXS),
      .DEBOUNCE_CYCLES (DEB),
      .DASH_UNITS      (3),
      .LONG_PRESS_UNITS(10),
      .LETTER_GAP_UNITS(3),
      .WORD_GAP_UNITS  (7)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .button_i   (button_i),
      .code_o     (code_o),
      .sym_count_o(sym_count_o),
      .word_end_o (word_end_o),
      .error_o    (error_o),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .overrun_o  (overrun_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Monitor on the falling edge: accepted frames, valid rises, drops, hold stability.
   always @(negedge clk) begin
      if (rst) begin
         prevHold  = 1'b0;
         prevValid = 1'b0;
      end else begin
         curFrame = {code_o, sym_count_o, error_o, word_end_o};
         if (out_valid_o && !prevValid) riseCyc.push_back(cyc);
         if (prevHold && out_valid_o && curFrame !== prevFrame) unstableCycles++;
         if (out_valid_o && out_ready_i) obsQ.push_back(curFrame);
         if (overrun_o) overrunCycles++;
         prevHold  = out_valid_o && !out_ready_i;
         prevFrame = curFrame;
         prevValid = out_valid_o;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit level, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         button_i = level;
         btnHist.push_back(level);
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] obsAt(input int k);
      if (k < obsQ.size()) return 32'(obsQ[k]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] riseAt(input int k);
      if (k < riseCyc.size()) return 32'(riseCyc[k]);
      return 32'hFFFF_FFFF;
   endfunction

   task automatic clearRecords();
      btnHist.delete();
      obsQ.delete();
      riseCyc.delete();
      overrunCycles  = 0;
      unstableCycles = 0;
   endtask

   task automatic startScenario();
      rst         = 1'b1;
      button_i    = 1'b0;
      out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clearRecords();
   endtask

   // Reference: filter the sampled key with a sliding window, then walk the
   // resulting high/low runs and apply the letter/word rules by run length.
   task automatic buildModel();
      bit key;
      bit flip;
      bit keySeq[$];
      bit lvl;
      bit open;
      bit armed;
      bit err;
      int code;
      int cnt;
      int len;
      int i;
      frame_t f;
      expQ.delete();
      key = 1'b0;
      for (int n = 0; n < btnHist.size(); n++) begin
         flip = 1'b1;
         for (int j = 0; j < DEB; j++) begin
            if (n - j < 0) flip = 1'b0;
            else if (btnHist[n - j] == key) flip = 1'b0;
         end
         if (flip) key = !key;
         keySeq.push_back(key);
      end
      open = 0; armed = 0; err = 0; code = 0; cnt = 0; i = 0;
      while (i < keySeq.size()) begin
         lvl = keySeq[i];
         len = 0;
         while (i < keySeq.size() && keySeq[i] == lvl) begin
            len++;
            i++;
         end
         if (lvl) begin
            armed = 0;
            open  = 1;
            if (len >= LONG_T || cnt >= MAXS) err = 1;
            else begin
               code = code * 4 + ((len < DASH_T) ? 1 : 2);
               cnt++;
            end
         end else begin
            if (open && len >= LETTER_T) begin
               f.code = 8'(code); f.cnt = 3'(cnt); f.err = err; f.word = 1'b0;
               expQ.push_back(f);
               open = 0; armed = 1; err = 0; code = 0; cnt = 0;
            end
            if (armed && len >= WORD_T) begin
               f = '0;
               f.word = 1'b1;
               expQ.push_back(f);
               armed = 0;
            end
         end
      end
   endtask

   task automatic finishScenario(input string name, input int dropIdx, input int expOverrun);
      applyStimulus(1'b0, WORD_T + 16);
      buildModel();
      if (dropIdx >= 0 && dropIdx < expQ.size()) expQ.delete(dropIdx);
      checkOutput({name, ".frames"}, obsQ.size(), expQ.size());
      for (int k = 0; k < expQ.size(); k++)
         checkOutput($sformatf("%s.frame%0d", name, k), obsAt(k), 32'(expQ[k]));
      checkOutput({name, ".overrun"}, overrunCycles, expOverrun);
      checkOutput({name, ".stable"}, unstableCycles, 0);
      checkOutput({name, ".idle"}, busy_o, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.outputs",
                  {code_o, sym_count_o, word_end_o, error_o, out_valid_o, overrun_o, busy_o}, 0);

      startScenario();
      applyStimulus(1'b1, 4);
      applyStimulus(1'b0, 6);
      applyStimulus(1'b1, 16);
      fallRef = cyc;
      applyStimulus(1'b0, 20);
      finishScenario("clean", -1, 0);
      checkOutput("clean.letter", obsAt(0), {8'h06, 3'd2, 1'b0, 1'b0});
      checkOutput("clean.word", obsAt(1), {8'h00, 3'd0, 1'b0, 1'b1});
      checkOutput("clean.latency", riseAt(0), fallRef + 1 + 2 + DEB + LETTER_T);

      startScenario();
      applyStimulus(1'b1, 4);
      applyStimulus(1'b0, 2);
      applyStimulus(1'b1, 1);
      applyStimulus(1'b0, 3);
      applyStimulus(1'b1, 16);
      applyStimulus(1'b0, 5);
      applyStimulus(1'b1, 1);
      applyStimulus(1'b0, 14);
      finishScenario("glitch", -1, 0);
      checkOutput("glitch.letter", obsAt(0), {8'h06, 3'd2, 1'b0, 1'b0});

      startScenario();
      for (int d = 0; d < 5; d++) begin
         applyStimulus(1'b1, 4);
         applyStimulus(1'b0, 4);
      end
      finishScenario("overflow", -1, 0);
      checkOutput("overflow.letter", obsAt(0), {8'h55, 3'd4, 1'b1, 1'b0});

      startScenario();
      applyStimulus(1'b1, 50);
      finishScenario("longpress", -1, 0);
      checkOutput("longpress.letter", obsAt(0), {8'h00, 3'd0, 1'b1, 1'b0});

      startScenario();
      out_ready_i = 1'b0;
      applyStimulus(1'b1, 4);
      applyStimulus(1'b0, 14);
      applyStimulus(1'b1, 16);
      applyStimulus(1'b0, 20);
      checkOutput("overrun.held", {out_valid_o, code_o, sym_count_o}, {1'b1, 8'h01, 3'd1});
      out_ready_i = 1'b1;
      finishScenario("overrun", 1, 1);

      startScenario();
      applyStimulus(1'b1, 10);
      checkOutput("rst.busy", busy_o, 1'b1);
      rst      = 1'b1;
      button_i = 1'b0;
      @(negedge clk);
      checkOutput("rst.outputs",
                  {code_o, sym_count_o, word_end_o, error_o, out_valid_o, overrun_o, busy_o}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clearRecords();
      applyStimulus(1'b1, 4);
      finishScenario("rst", -1, 0);
      checkOutput("rst.dot", obsAt(0), {8'h01, 3'd1, 1'b0, 1'b0});

      for (int r = 0; r < 8; r++) begin
         startScenario();
         for (int s = 0; s < int'($urandom_range(2, 6)); s++) begin
            applyStimulus(1'b1, int'($urandom_range(1, 48)));
            applyStimulus(1'b0, int'($urandom_range(1, 34)));
         end
         finishScenario($sformatf("rand%0d", r), -1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
